// File: rtl/input_pkg.sv
// Shared types and helpers for the controller-source arbiter.
package input_pkg;

  typedef enum logic [1:0] {
    SRC_PS2 = 2'd0,
    SRC_IR  = 2'd1,
    SRC_NES = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    HANDOFF
  } arb_state_e;

  // Bit positions inside a 4-bit {Up,Down,Left,Right} direction vector
  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  // Highest-priority readable source (PS/2 > IR > NES), skipping 'exclude'.
  // Pass exclude=3 to consider every source.
  function automatic src_e pri_pick(input logic [2:0] readable, input logic [1:0] exclude);
    logic [2:0] m;
    m = readable & ~{exclude == 2'd2, exclude == 2'd1, exclude == 2'd0};
    if (m[0]) begin
      pri_pick = SRC_PS2;
    end else if (m[1]) begin
      pri_pick = SRC_IR;
    end else begin
      pri_pick = SRC_NES;
    end
  endfunction

endpackage

// File: rtl/input_source_arbiter_if.sv
// Source strobes/directions in, granted selection and owner directions out.
interface input_source_arbiter_if;
  logic       PReadable;
  logic [3:0] PDir;
  logic       IReadable;
  logic [3:0] IDir;
  logic       NReadable;
  logic [3:0] NDir;
`ifdef MANUAL_OVERRIDE_EN
  logic       ManualMode;
  logic [1:0] ManualChoice;
`endif
  logic [1:0] Choice;
  logic       Active;
  logic       Up;
  logic       Down;
  logic       Left;
  logic       Right;
  logic       Switched;

  modport master (
    output PReadable, PDir, IReadable, IDir, NReadable, NDir,
`ifdef MANUAL_OVERRIDE_EN
    output ManualMode, ManualChoice,
`endif
    input  Choice, Active, Up, Down, Left, Right, Switched
  );

  modport slave (
    input  PReadable, PDir, IReadable, IDir, NReadable, NDir,
`ifdef MANUAL_OVERRIDE_EN
    input  ManualMode, ManualChoice,
`endif
    output Choice, Active, Up, Down, Left, Right, Switched
  );
endinterface

// File: rtl/quiet_timer.sv
// Saturating owner-quiet counter with hold/idle threshold flags.
module quiet_timer #(
  parameter int unsigned HOLD_CYCLES = 4096,
  parameter int unsigned IDLE_CYCLES = 65536
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic hold_hit,
  output logic idle_hit
);

  localparam int unsigned CntW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CntW-1:0] HoldVal = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] IdleVal = CntW'(IDLE_CYCLES);

  logic [CntW-1:0] cnt_q;

  // Clear wins over increment; count sticks at IdleVal.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != IdleVal)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign hold_hit = (cnt_q >= HoldVal);
  assign idle_hit = (cnt_q >= IdleVal);

endmodule

// File: rtl/input_source_arbiter.sv
// Automatic PS/2 / IR / NES source scheduler feeding the direction decoder.
// Optional build macro MANUAL_OVERRIDE_EN adds ManualMode/ManualChoice.
module input_source_arbiter
  import input_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4096,
  parameter int unsigned IDLE_CYCLES = 65536
) (
  input logic                   CLK,
  input logic                   RST,
  input_source_arbiter_if.slave bus
);

  arb_state_e state_q;
  src_e       choice_q;
  src_e       target_q;
  logic       active_q;
  logic       switched_q;
  logic [3:0] dir_q;

  logic [2:0] rd;
  logic [2:0] rd_others;
  logic       owner_rd;
  logic [3:0] owner_dir;
  logic       hold_hit;
  logic       idle_hit;
  logic       timer_inc;
  logic       manual_on;
  logic       manual_req;
  src_e       manual_tgt;

  assign rd        = {bus.NReadable, bus.IReadable, bus.PReadable};
  assign rd_others = rd & ~{choice_q == SRC_NES, choice_q == SRC_IR, choice_q == SRC_PS2};

  // Select the owner's strobe and directions.
  always_comb begin
    owner_rd  = 1'b0;
    owner_dir = '0;
    case (choice_q)
      SRC_PS2: begin
        owner_rd  = bus.PReadable;
        owner_dir = bus.PDir;
      end
      SRC_IR: begin
        owner_rd  = bus.IReadable;
        owner_dir = bus.IDir;
      end
      default: begin
        owner_rd  = bus.NReadable;
        owner_dir = bus.NDir;
      end
    endcase
  end

`ifdef MANUAL_OVERRIDE_EN
  logic manual_q;
  src_e manual_src;

  // ManualChoice of 3 folds onto NES.
  always_comb begin
    case (bus.ManualChoice)
      2'd0:    manual_src = SRC_PS2;
      2'd1:    manual_src = SRC_IR;
      default: manual_src = SRC_NES;
    endcase
  end

  assign manual_on  = manual_q;
  // Mode edges and source changes while manual both go through a handoff.
  assign manual_req = (bus.ManualMode != manual_q) || (manual_q && (manual_src != choice_q));
  // Leaving manual keeps the manual source as the new automatic owner.
  assign manual_tgt = bus.ManualMode ? manual_src : choice_q;
`else
  assign manual_on  = 1'b0;
  assign manual_req = 1'b0;
  assign manual_tgt = SRC_PS2;
`endif

  // Count only while an automatic owner is quiet; every other cycle zeroes it.
  assign timer_inc = (state_q == OWN) && !owner_rd && !manual_on;

  quiet_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_quiet_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (!timer_inc),
    .inc      (timer_inc),
    .hold_hit (hold_hit),
    .idle_hit (idle_hit)
  );

  // Arbitration FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      choice_q   <= SRC_PS2;
      target_q   <= SRC_PS2;
      active_q   <= 1'b0;
      switched_q <= 1'b0;
      dir_q      <= '0;
`ifdef MANUAL_OVERRIDE_EN
      manual_q   <= 1'b0;
`endif
    end else begin
      switched_q <= 1'b0;
`ifdef MANUAL_OVERRIDE_EN
      if ((state_q != HANDOFF) && manual_req) begin
        manual_q <= bus.ManualMode;
      end
`endif
      case (state_q)
        IDLE: begin
          dir_q <= '0;
          if (manual_req) begin
            target_q <= manual_tgt;
            state_q  <= HANDOFF;
          end else if (|rd) begin
            choice_q   <= pri_pick(rd, 2'd3);
            active_q   <= 1'b1;
            switched_q <= 1'b1;
            state_q    <= OWN;
          end
        end
        OWN: begin
          if (manual_req) begin
            target_q <= manual_tgt;
            dir_q    <= '0;
            state_q  <= HANDOFF;
          end else if (owner_rd) begin
            dir_q <= owner_dir;
          end else if (!manual_on && hold_hit && (|rd_others)) begin
            // Checked before release so a waiting challenger beats going idle
            target_q <= pri_pick(rd, choice_q);
            dir_q    <= '0;
            state_q  <= HANDOFF;
          end else if (!manual_on && idle_hit) begin
            active_q <= 1'b0;
            dir_q    <= '0;
            state_q  <= IDLE;
          end else begin
            dir_q <= '0;
          end
        end
        HANDOFF: begin
          dir_q      <= '0;
          choice_q   <= target_q;
          active_q   <= 1'b1;
          switched_q <= 1'b1;
          state_q    <= OWN;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Choice   = choice_q;
  assign bus.Active   = active_q;
  assign bus.Switched = switched_q;
  assign bus.Up       = dir_q[DIR_UP];
  assign bus.Down     = dir_q[DIR_DOWN];
  assign bus.Left     = dir_q[DIR_LEFT];
  assign bus.Right    = dir_q[DIR_RIGHT];

endmodule
